// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port synchronous SRAM between the core's
//            instruction-fetch port and data-memory port. At most one access
//            is issued per cycle. Read data returns one cycle after the grant
//            and is routed to the requester that won that grant.
// Ports    : clk, reset (async, active-high)
//            i_req/i_addr -> i_gnt, i_rvalid, i_rdata      (fetch port)
//            d_req/d_addr/d_wdata/d_wr_en -> d_gnt, d_rvalid, d_rdata (data)
//            mem_en/mem_addr/mem_wdata/mem_wr_en, mem_rdata (SRAM side)
//            conf_cnt : saturating count of contested cycles
// Config   : ARB_ROUND_ROBIN_EN -- when defined, contested cycles alternate
//            between requesters; otherwise data always beats fetch.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WIDTH-1:0]  i_rdata,
  input  logic              d_req,
  input  logic [ADDR-1:0]   d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  input  logic [3:0]        d_wr_en,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              mem_en,
  output logic [ADDR-3:0]   mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [3:0]        mem_wr_en,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [15:0]       conf_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  owner_t           rd_owner;
  owner_t           rd_owner_next;
  logic             grant_fetch;
  logic             grant_data;
  logic             prefer_data;
  logic             contested;
  logic [WIDTH-1:0] i_rdata_hold;
  logic [WIDTH-1:0] d_rdata_hold;

  // Byte-offset bits never reach the word-addressed SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign contested = i_req & d_req & ~reset;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;

  // Starts at FETCH so the first contest after reset goes to data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWN_FETCH;
    end else if (grant_data) begin
      last_owner <= OWN_DATA;
    end else if (grant_fetch) begin
      last_owner <= OWN_FETCH;
    end
  end

  assign prefer_data = (last_owner != OWN_DATA);
`else
  // The MEM-stage access is older than the fetch, so it always wins.
  assign prefer_data = 1'b1;
`endif

  // Grant selection and read tagging; no grants while reset is high.
  always_comb begin
    grant_fetch   = 1'b0;
    grant_data    = 1'b0;
    rd_owner_next = OWN_NONE;
    if (!reset) begin
      if (d_req && (!i_req || prefer_data)) begin
        grant_data = 1'b1;
      end else if (i_req) begin
        grant_fetch = 1'b1;
      end
    end
    if (grant_fetch) begin
      rd_owner_next = OWN_FETCH;
    end else if (grant_data && (d_wr_en == 4'b0000)) begin
      rd_owner_next = OWN_DATA;
    end
  end

  assign i_gnt     = grant_fetch;
  assign d_gnt     = grant_data;
  assign mem_en    = grant_fetch | grant_data;
  assign mem_addr  = grant_data  ? d_addr[ADDR-1:2] :
                     grant_fetch ? i_addr[ADDR-1:2] : '0;
  assign mem_wr_en = grant_data ? d_wr_en : 4'b0000;
  assign mem_wdata = grant_data ? d_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_next;
    end
  end

  // rdata is presented straight from the SRAM in the return cycle and then
  // held from a capture register until the next return to that port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata_hold <= '0;
      d_rdata_hold <= '0;
    end else begin
      if (rd_owner == OWN_FETCH) begin
        i_rdata_hold <= mem_rdata;
      end
      if (rd_owner == OWN_DATA) begin
        d_rdata_hold <= mem_rdata;
      end
    end
  end

  assign i_rvalid = (rd_owner == OWN_FETCH);
  assign d_rvalid = (rd_owner == OWN_DATA);
  assign i_rdata  = i_rvalid ? mem_rdata : i_rdata_hold;
  assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conf_cnt <= 16'h0000;
    end else if (contested && (conf_cnt != 16'hFFFF)) begin
      conf_cnt <= conf_cnt + 16'h0001;
    end
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and data-memory port. It replaces separate imem/dmem macros when the SoC is built with a unified memory. The arbiter issues at most one memory access per cycle and returns read data one cycle later, tagged to the winning requester. The core stalls on a lost grant through its existing hazard stall path.

## Interface
- WIDTH, 32, data word width
- ADDR, 16, byte address width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  WIDTH  fetch read data, held
- d_req  in  1  data request (read or write)
- d_addr  in  ADDR  data byte address
- d_wdata  in  WIDTH  write data
- d_wr_en  in  4  byte write enables; 0 = read
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  WIDTH  data read data, held
- mem_en  out  1  SRAM access strobe
- mem_addr  out  ADDR-2  SRAM word address (byte address >> 2)
- mem_wdata  out  WIDTH  SRAM write data
- mem_wr_en  out  4  SRAM byte enables
- mem_rdata  in  WIDTH  SRAM read data, valid the cycle after mem_en
- conf_cnt  out  16  saturating count of contested cycles

## Operation
- Grant logic is combinational from requests and state. At most one of i_gnt/d_gnt is high in a cycle. A granted request drives mem_en=1, mem_addr, mem_wdata and mem_wr_en in the same cycle. With fetch granted, mem_wr_en=0.
- Requesters hold req, addr, wdata and wr_en stable until gnt. Deasserting req before gnt is legal and cancels the request with no memory side effect.
- Contested cycle: i_req=d_req=1. The default policy grants data, since the MEM-stage instruction is older. The fetch retries the next cycle.
- Read tag: register `rd_owner` ∈ {NONE, FETCH, DATA} is set on a granted read and cleared otherwise. It is cleared if the grant was a data write.
- Return: `rd_owner`=FETCH gives i_rvalid=1 and i_rdata←mem_rdata. DATA likewise gives d_rvalid and d_rdata. Each rdata register holds its last returned value until its next rvalid.
- Writes produce no rvalid. d_gnt is the write completion.
- Back-to-back accesses are allowed: a new grant in the same cycle as the previous read's rvalid.
- conf_cnt increments on each contested cycle and saturates at 16'hFFFF.
- Unaligned d_addr/i_addr: bits [1:0] are ignored. The byte lane is encoded in d_wr_en by the core.

## Timing
- Reset values: i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wr_en = 0. i_rdata, d_rdata, mem_addr, mem_wdata = 0. conf_cnt = 0. rd_owner = NONE. `last_owner` = FETCH.
- Grant latency: 0 cycles, same cycle as req, when uncontested.
- Read latency: rvalid exactly 1 cycle after gnt.
- Reset asserted mid-read: the pending rvalid is suppressed and rdata is cleared. No spurious rvalid follows deassertion.
- No grants are issued while reset is high, even with requests asserted.

## Configuration
- ARB_ROUND_ROBIN_EN defined: contested cycles grant the requester opposite `last_owner`. `last_owner` updates on every grant. After reset the first contest grants data, then alternates.
- ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority. `last_owner` is not implemented.

## Test plan
- Reset, then i_req=1 with i_addr=0x0010 and mem_rdata=0xDEADBEEF → i_gnt same cycle, mem_addr=0x0004, and next cycle i_rvalid=1 with i_rdata=0xDEADBEEF. i_rdata holds after i_req drops.
- d_req write with d_addr=0x0100, d_wdata=0x12345678, d_wr_en=4'b0011 → d_gnt=1, mem_wr_en=4'b0011, mem_addr=0x0040. No d_rvalid the next cycle.
- i_req and d_req both held for 3 cycles, fixed priority → d_gnt every cycle, i_gnt=0, conf_cnt=3. Drop d_req → i_gnt in the following cycle.
- Same stimulus with ARB_ROUND_ROBIN_EN defined → grants alternate D, I, D, and each rvalid is routed to the matching port.
- Data read granted, then reset asserted before the next edge → no d_rvalid after reset, d_rdata=0, and no mem_en while reset is high.
- Hold a contested condition for 70000 cycles → conf_cnt saturates at 0xFFFF and does not wrap.
